// File: rtl/ethpipe_rx_drain_pkg.sv
// Shared definitions for the RX slot drain: FSM encoding, header size, and the
// byte-enable mapping for the final (possibly partial) data word.
package ethpipe_rx_drain_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_HDR_TSH = 3'd1,
    ST_HDR_TSL = 3'd2,
    ST_HDR_LEN = 3'd3,
    ST_DATA    = 3'd4
  } rx_state_t;

  localparam int HDR_WORDS = 3;

  function automatic logic [3:0] byte_en_from_len(input logic [1:0] len_lsb);
    logic [3:0] be;
    case (len_lsb)
      2'b00:   be = 4'b1111;
      2'b01:   be = 4'b0001;
      2'b10:   be = 4'b0011;
      default: be = 4'b0111;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/ethpipe_rx_drain_skid.sv
// Two-entry buffer that catches slot RAM read data (1-cycle latency) so the
// stream can stall on dout_ready without losing an in-flight word.
module ethpipe_rx_drain_skid
  import ethpipe_rx_drain_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             pci_clk,
  input  logic             sys_rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [1:0]       count
);

  logic             wr_ptr_reg;
  logic             rd_ptr_reg;
  logic [1:0]       count_reg;
  logic [WIDTH-1:0] entry [2];

  genvar gi;
  for (gi = 0; gi < 2; gi++) begin : g_entry
    logic [WIDTH-1:0] word_reg;
    always_ff @(posedge pci_clk) begin
      if (push && (wr_ptr_reg == 1'(gi))) begin
        word_reg <= din;
      end
    end
    assign entry[gi] = word_reg;
  end

  always_ff @(posedge pci_clk) begin
    if (sys_rst) begin
      wr_ptr_reg <= 1'b0;
      rd_ptr_reg <= 1'b0;
      count_reg  <= 2'd0;
    end else begin
      if (push) wr_ptr_reg <= ~wr_ptr_reg;
      if (pop)  rd_ptr_reg <= ~rd_ptr_reg;
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 2'd1;
        2'b01:   count_reg <= count_reg - 2'd1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign head  = entry[rd_ptr_reg];
  assign count = count_reg;

endmodule

// File: rtl/ethpipe_rx_drain.sv
// RX slot drain: emits {TS hi, TS lo, length} then frame data words as a valid/ready stream.
// Build option ETHPIPE_RX_FCS_STRIP_EN removes the 4 trailing FCS bytes from the length.
module ethpipe_rx_drain
  import ethpipe_rx_drain_pkg::*;
#(
  parameter logic [10:0] DATA_START_ADDR = 11'd5,
  parameter logic [11:0] MAX_FRAME_LEN   = 12'd1518
) (
  input  logic        pci_clk,
  input  logic        sys_rst,
  input  logic        rx_complete,
  input  logic [63:0] rx_timestamp,
  input  logic [11:0] rx_frame_len,
  output logic        rx_empty,
  output logic [10:0] slot_rx_pci_address,
  output logic        slot_rx_pci_rd_en,
  input  logic [31:0] slot_rx_pci_q,
  output logic [31:0] dout,
  output logic [3:0]  dout_byte_en,
  output logic        dout_valid,
  output logic        dout_last,
  input  logic        dout_ready
);

  rx_state_t   state_reg, state_next;
  logic [63:0] ts_reg;
  logic [11:0] eff_len_reg;
  logic [12:0] rd_left_reg;
  logic [12:0] words_left_reg;
  logic [10:0] rd_addr_reg;
  logic        inflight_reg;
  logic        rx_empty_reg;

  logic [11:0] len_adj;
  logic [11:0] eff_len_in;
  logic [12:0] nwords_in;
  logic [31:0] hdr_word [HDR_WORDS];
  logic [31:0] skid_head;
  logic [1:0]  skid_count;
  logic [1:0]  skid_level;
  logic        skid_pop;
  logic        rd_room;

`ifdef ETHPIPE_RX_FCS_STRIP_EN
  assign len_adj = (rx_frame_len >= 12'd4) ? (rx_frame_len - 12'd4) : 12'd0;
`else
  assign len_adj = rx_frame_len;
`endif
  assign eff_len_in = (len_adj > MAX_FRAME_LEN) ? MAX_FRAME_LEN : len_adj;
  assign nwords_in  = ({1'b0, eff_len_in} + 13'd3) >> 2;

  assign hdr_word[0] = ts_reg[63:32];
  assign hdr_word[1] = ts_reg[31:0];
  assign hdr_word[2] = {20'h0, eff_len_reg};

  ethpipe_rx_drain_skid #(.WIDTH(32)) u_skid (
    .pci_clk (pci_clk),
    .sys_rst (sys_rst),
    .push    (inflight_reg),
    .din     (slot_rx_pci_q),
    .pop     (skid_pop),
    .head    (skid_head),
    .count   (skid_count)
  );

  // A read may issue when the word it returns is sure to find a free slot,
  // counting one being popped this same cycle; that keeps DATA bubble-free.
  assign skid_level = skid_count + {1'b0, inflight_reg};
  assign rd_room    = (skid_level < 2'd2) || ((skid_level == 2'd2) && skid_pop);
  assign slot_rx_pci_rd_en   = (state_reg != ST_IDLE) && (rd_left_reg != 13'd0) && rd_room;
  assign slot_rx_pci_address = rd_addr_reg;
  assign rx_empty            = rx_empty_reg;

  always_comb begin
    state_next   = state_reg;
    dout         = 32'h0;
    dout_byte_en = 4'h0;
    dout_valid   = 1'b0;
    dout_last    = 1'b0;
    skid_pop     = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (rx_complete) state_next = ST_HDR_TSH;
      end
      ST_HDR_TSH: begin
        dout         = hdr_word[0];
        dout_byte_en = 4'hF;
        dout_valid   = 1'b1;
        if (dout_ready) state_next = ST_HDR_TSL;
      end
      ST_HDR_TSL: begin
        dout         = hdr_word[1];
        dout_byte_en = 4'hF;
        dout_valid   = 1'b1;
        if (dout_ready) state_next = ST_HDR_LEN;
      end
      ST_HDR_LEN: begin
        dout         = hdr_word[2];
        dout_byte_en = 4'hF;
        dout_valid   = 1'b1;
        dout_last    = (words_left_reg == 13'd0);
        if (dout_ready) state_next = dout_last ? ST_IDLE : ST_DATA;
      end
      ST_DATA: begin
        dout         = skid_head;
        dout_valid   = (skid_count != 2'd0);
        dout_last    = (words_left_reg == 13'd1);
        dout_byte_en = dout_last ? byte_en_from_len(eff_len_reg[1:0]) : 4'hF;
        skid_pop     = dout_valid && dout_ready;
        if (skid_pop && dout_last) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge pci_clk) begin
    if (sys_rst) begin
      state_reg      <= ST_IDLE;
      rx_empty_reg   <= 1'b1;
      inflight_reg   <= 1'b0;
      rd_addr_reg    <= 11'd0;
      rd_left_reg    <= 13'd0;
      words_left_reg <= 13'd0;
      ts_reg         <= 64'h0;
      eff_len_reg    <= 12'h0;
    end else begin
      state_reg    <= state_next;
      rx_empty_reg <= (state_next == ST_IDLE);
      inflight_reg <= slot_rx_pci_rd_en;
      if ((state_reg == ST_IDLE) && rx_complete) begin
        ts_reg         <= rx_timestamp;
        eff_len_reg    <= eff_len_in;
        rd_addr_reg    <= DATA_START_ADDR;
        rd_left_reg    <= nwords_in;
        words_left_reg <= nwords_in;
      end else begin
        if (slot_rx_pci_rd_en) begin
          rd_addr_reg <= rd_addr_reg + 11'd1;
          rd_left_reg <= rd_left_reg - 13'd1;
        end
        if (skid_pop) words_left_reg <= words_left_reg - 13'd1;
      end
    end
  end

endmodule
